// File: rtl/spiflash_shift_engine.sv
// SPI mode-0 byte shifter: pops TX FIFO bytes out on MOSI MSB-first and optionally
// pushes the captured MISO bytes into the RX FIFO, stalling with SCLK low on FIFO flow control.
module spiflash_shift_engine #(
  parameter int unsigned CLKDIV = 2,
  parameter int unsigned LENW   = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [LENW-1:0] i_len,
  input  logic            i_rx_en,
  output logic            o_busy,
  output logic            o_done,
  input  logic            i_tx_empty,
  input  logic [7:0]      i_tx_data,
  output logic            o_tx_rd,
  output logic            o_rx_wr_en,
  output logic [7:0]      o_rx_data,
  input  logic            i_rx_full,
  output logic            o_sclk,
  output logic            o_cs_n,
  output logic            o_mosi,
  input  logic            i_miso
);

  localparam int unsigned CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_LOAD, S_SHIFT, S_RX_PUSH, S_CS_HOLD
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_n;
  logic [LENW-1:0] remaining, rem_n;
  logic            rx_en_q, rx_en_n;
  logic [6:0]      tx_sh, tx_sh_n;
  logic [7:0]      rx_sh, rx_sh_n;
  logic            busy_n, done_n, sclk_n, cs_n_n, mosi_n;
  logic [7:0]      rx_data_n;
  logic            tx_rd_c, rx_wr_c, phase_end;

  // FIFO strobes are combinational so they can react to empty/full in the same cycle
  assign o_tx_rd    = tx_rd_c & ~i_reset;
  assign o_rx_wr_en = rx_wr_c & ~i_reset;

  // Next-state and datapath decode
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_idx;
    rem_n     = remaining;
    rx_en_n   = rx_en_q;
    tx_sh_n   = tx_sh;
    rx_sh_n   = rx_sh;
    busy_n    = o_busy;
    done_n    = 1'b0;
    sclk_n    = o_sclk;
    cs_n_n    = o_cs_n;
    mosi_n    = o_mosi;
    rx_data_n = o_rx_data;
    tx_rd_c   = 1'b0;
    rx_wr_c   = 1'b0;
    phase_end = (cnt == CNT_LAST);

    case (state)
      S_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            rem_n   = i_len;
            rx_en_n = i_rx_en;
            busy_n  = 1'b1;
            cs_n_n  = 1'b0;
            cnt_n   = '0;
            state_n = S_CS_SETUP;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      S_CS_SETUP: begin
        if (phase_end) begin
          cnt_n   = '0;
          state_n = S_LOAD;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_LOAD: begin
        if (!i_tx_empty) begin
          tx_rd_c = 1'b1;
          tx_sh_n = i_tx_data[6:0];
          mosi_n  = i_tx_data[7];
          bit_n   = '0;
          cnt_n   = '0;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!phase_end) begin
          cnt_n = cnt + CW'(1);
        end else begin
          cnt_n = '0;
          if (!o_sclk) begin
            sclk_n  = 1'b1;
            rx_sh_n = {rx_sh[6:0], i_miso};
          end else begin
            sclk_n = 1'b0;
            if (bit_idx == 3'd7) begin
              rem_n     = remaining - LENW'(1);
              rx_data_n = rx_sh;
              state_n   = S_RX_PUSH;
            end else begin
              tx_sh_n = {tx_sh[5:0], 1'b0};
              mosi_n  = tx_sh[6];
              bit_n   = bit_idx + 3'd1;
            end
          end
        end
      end
      S_RX_PUSH: begin
        if (!(rx_en_q && i_rx_full)) begin
          rx_wr_c = rx_en_q;
          cnt_n   = '0;
          state_n = (remaining != '0) ? S_LOAD : S_CS_HOLD;
        end
      end
      S_CS_HOLD: begin
        if (phase_end) begin
          cnt_n   = '0;
          cs_n_n  = 1'b1;
          mosi_n  = 1'b0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      remaining <= '0;
      rx_en_q   <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_sclk    <= 1'b0;
      o_cs_n    <= 1'b1;
      o_mosi    <= 1'b0;
      o_rx_data <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      remaining <= rem_n;
      rx_en_q   <= rx_en_n;
      tx_sh     <= tx_sh_n;
      rx_sh     <= rx_sh_n;
      o_busy    <= busy_n;
      o_done    <= done_n;
      o_sclk    <= sclk_n;
      o_cs_n    <= cs_n_n;
      o_mosi    <= mosi_n;
      o_rx_data <= rx_data_n;
    end
  end

endmodule
